// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard-unit bundle between the pipeline datapath and
// the stall/redirect sequencer. The slave modport is the sequencer side and
// the master modport is the datapath side.
interface pipe_hazard_ctrl_if;
  // ID-stage operand information
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_redirect;
  // EXE-stage producer information
  logic        exe_is_load;
  logic        exe_wena;
  logic [4:0]  exe_waddr;
  logic        exe_md_start;
  // Pipeline control outputs
  logic [1:0]  if_pc_sel;
  logic        ifid_en;
  logic        idex_en;
  logic        idex_bubble;
  logic        exmem_en;
  logic        exmem_bubble;
  logic        md_busy;
  logic [31:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_redirect,
    output exe_is_load, exe_wena, exe_waddr, exe_md_start,
    input  if_pc_sel, ifid_en, idex_en, idex_bubble,
    input  exmem_en, exmem_bubble, md_busy, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_redirect,
    input  exe_is_load, exe_wena, exe_waddr, exe_md_start,
    output if_pc_sel, ifid_en, idex_en, idex_bubble,
    output exmem_en, exmem_bubble, md_busy, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/redirect sequencer for the 5-stage pipeline.
// Chooses the IF PC source, drives pipeline-register enables and bubbles,
// inserts one bubble per load-use hazard and freezes the front end while a
// multi-cycle DIV/DIVU occupies EXE for exactly MD_CYCLES cycles.
// Optional feature: define STALL_PERF_CNT_EN to build the 32-bit stall-cycle
// counter; without it stall_cycles is tied to zero.
module pipe_hazard_ctrl #(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = $clog2(MD_CYCLES)
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;
  localparam logic [1:0] PC_HOLD   = 2'b10;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_md_busy;

  logic       w_lu;
  logic       w_run;
  logic       w_freeze;
  logic [1:0] w_if_pc_sel;
  logic       w_ifid_en;
  logic       w_idex_en;
  logic       w_idex_bubble;
  logic       w_exmem_en;
  logic       w_exmem_bubble;

  // Load-use hazard: EXE load writes a nonzero register that ID reads.
  assign w_lu = bus.exe_is_load & bus.exe_wena & (bus.exe_waddr != 5'd0) &
                ((bus.id_uses_rs & (bus.id_rs == bus.exe_waddr)) |
                 (bus.id_uses_rt & (bus.id_rt == bus.exe_waddr)));

  // Reset forces RUN behaviour on the outputs even if the state is MD_WAIT.
  assign w_run    = rst | (r_state == ST_RUN);
  assign w_freeze = ~w_run | bus.exe_md_start;

  // Output decode by priority: divide freeze, load-use bubble, redirect, sequential.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and a latch is never inferred.
    w_if_pc_sel    = PC_SEQ;
    w_ifid_en      = 1'b1;
    w_idex_en      = 1'b1;
    w_idex_bubble  = 1'b0;
    w_exmem_en     = 1'b1;
    w_exmem_bubble = 1'b0;
    if (w_freeze) begin
      w_if_pc_sel    = PC_HOLD;
      w_ifid_en      = 1'b0;
      w_idex_en      = 1'b0;
      w_exmem_bubble = 1'b1;
    end else if (w_lu) begin
      w_if_pc_sel    = PC_HOLD;
      w_ifid_en      = 1'b0;
      w_idex_bubble  = 1'b1;
    end else if (bus.id_redirect) begin
      w_if_pc_sel    = PC_TARGET;
    end
  end

  // RUN/MD_WAIT sequencer with occupancy down-counter and registered busy flag.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update together from pre-edge values.
    if (rst) begin
      r_state   <= ST_RUN;
      r_cnt     <= '0;
      r_md_busy <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.exe_md_start) begin
            // The start cycle counts as the first of MD_CYCLES, and the
            // cnt==0 cycle is the last MD_WAIT cycle, hence MD_CYCLES-2.
            r_state   <= ST_MD_WAIT;
            r_cnt     <= CNT_W'(MD_CYCLES - 2);
            r_md_busy <= 1'b1;
          end
        end
        ST_MD_WAIT: begin
          if (r_cnt == '0) begin
            r_state   <= ST_RUN;
            r_md_busy <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state   <= ST_RUN;
          r_md_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  // Count every non-reset cycle in which IF holds its PC; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_if_pc_sel == PC_HOLD) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
`else
  assign bus.stall_cycles = 32'd0;
`endif

  assign bus.if_pc_sel    = w_if_pc_sel;
  assign bus.ifid_en      = w_ifid_en;
  assign bus.idex_en      = w_idex_en;
  assign bus.idex_bubble  = w_idex_bubble;
  assign bus.exmem_en     = w_exmem_en;
  assign bus.exmem_bubble = w_exmem_bubble;
  assign bus.md_busy      = r_md_busy;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed, table-driven bench for pipe_hazard_ctrl with
// MD_CYCLES=4. Inputs change on the falling edge; outputs are compared 1 ns
// later, well away from the rising edge that updates state.
module tb_pipe_hazard_ctrl;

  localparam int MD_CYCLES = 4;

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       redir;
    logic       ld;
    logic       wena;
    logic [4:0] waddr;
    logic       md;
    logic [1:0] e_sel;
    logic       e_ifid;
    logic       e_idex;
    logic       e_idb;
    logic       e_exm;
    logic       e_exb;
    logic       e_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_stall = 32'd0;

  pipe_hazard_ctrl_if u_if ();

  pipe_hazard_ctrl #(.MD_CYCLES(MD_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Build a vector: inputs first, expected outputs last.
  function automatic vec_t mk(
    input logic r, input logic [4:0] rs_i, input logic [4:0] rt_i,
    input logic urs_i, input logic urt_i, input logic redir_i,
    input logic ld_i, input logic wena_i, input logic [4:0] waddr_i, input logic md_i,
    input logic [1:0] sel, input logic ifid, input logic idex, input logic idb,
    input logic exm, input logic exb, input logic busy);
    vec_t v;
    v.rst = r; v.rs = rs_i; v.rt = rt_i; v.urs = urs_i; v.urt = urt_i;
    v.redir = redir_i; v.ld = ld_i; v.wena = wena_i; v.waddr = waddr_i; v.md = md_i;
    v.e_sel = sel; v.e_ifid = ifid; v.e_idex = idex; v.e_idb = idb;
    v.e_exm = exm; v.e_exb = exb; v.e_busy = busy;
    return v;
  endfunction

  // Apply one vector for one cycle; optionally compare outputs, then track the counter.
  task automatic apply(input vec_t v, input string tag, input bit do_chk);
    @(negedge clk);
    rst                = v.rst;
    u_if.id_rs         = v.rs;
    u_if.id_rt         = v.rt;
    u_if.id_uses_rs    = v.urs;
    u_if.id_uses_rt    = v.urt;
    u_if.id_redirect   = v.redir;
    u_if.exe_is_load   = v.ld;
    u_if.exe_wena      = v.wena;
    u_if.exe_waddr     = v.waddr;
    u_if.exe_md_start  = v.md;
    #1;
    if (do_chk) begin
      check({tag, ".if_pc_sel"},    32'(u_if.if_pc_sel),    32'(v.e_sel));
      check({tag, ".ifid_en"},      32'(u_if.ifid_en),      32'(v.e_ifid));
      check({tag, ".idex_en"},      32'(u_if.idex_en),      32'(v.e_idex));
      check({tag, ".idex_bubble"},  32'(u_if.idex_bubble),  32'(v.e_idb));
      check({tag, ".exmem_en"},     32'(u_if.exmem_en),     32'(v.e_exm));
      check({tag, ".exmem_bubble"}, 32'(u_if.exmem_bubble), 32'(v.e_exb));
      check({tag, ".md_busy"},      32'(u_if.md_busy),      32'(v.e_busy));
      check({tag, ".stall_cycles"}, u_if.stall_cycles,      exp_stall);
    end
`ifdef STALL_PERF_CNT_EN
    if (v.rst) exp_stall = 32'd0;
    else if (v.e_sel == 2'b10) exp_stall = exp_stall + 32'd1;
`endif
  endtask

  vec_t tbl[$];
  vec_t v_rst, v_idle, v_md, v_hz, v_hz_md;

  initial begin
    u_if.id_rs = '0; u_if.id_rt = '0; u_if.id_uses_rs = 1'b0; u_if.id_uses_rt = 1'b0;
    u_if.id_redirect = 1'b0; u_if.exe_is_load = 1'b0; u_if.exe_wena = 1'b0;
    u_if.exe_waddr = '0; u_if.exe_md_start = 1'b0;
    repeat (2) @(posedge clk);

    //        rst rs    rt    urs urt red ld  we  waddr md  sel    ifid idex idb exm exb busy
    v_rst  = mk(1, 5'd0, 5'd0, 0,  0,  0,  0,  0,  5'd0, 0, 2'b00, 1,   1,   0,  1,  0,  0);
    v_idle = mk(0, 5'd0, 5'd0, 0,  0,  0,  0,  0,  5'd0, 0, 2'b00, 1,   1,   0,  1,  0,  0);
    v_md   = mk(0, 5'd0, 5'd0, 0,  0,  0,  0,  0,  5'd0, 1, 2'b10, 0,   0,   0,  1,  1,  0);

    // Single-cycle combinational cases, each from RUN.
    tbl.push_back(v_rst);
    tbl.push_back(v_idle);
    tbl.push_back(mk(0, 5'd5, 5'd0, 1, 0, 0, 1, 1, 5'd5, 0, 2'b10, 0, 1, 1, 1, 0, 0)); // lu on rs
    tbl.push_back(mk(0, 5'd5, 5'd0, 1, 0, 0, 0, 0, 5'd0, 0, 2'b00, 1, 1, 0, 1, 0, 0)); // load now in MEM
    tbl.push_back(mk(0, 5'd0, 5'd0, 1, 0, 0, 1, 1, 5'd0, 0, 2'b00, 1, 1, 0, 1, 0, 0)); // $0 destination
    tbl.push_back(mk(0, 5'd7, 5'd7, 0, 1, 0, 1, 1, 5'd7, 0, 2'b10, 0, 1, 1, 1, 0, 0)); // lu on rt
    tbl.push_back(mk(0, 5'd7, 5'd7, 0, 0, 0, 1, 1, 5'd7, 0, 2'b00, 1, 1, 0, 1, 0, 0)); // match, not used
    tbl.push_back(mk(0, 5'd9, 5'd0, 1, 0, 0, 1, 0, 5'd9, 0, 2'b00, 1, 1, 0, 1, 0, 0)); // load, no write
    tbl.push_back(mk(0, 5'd9, 5'd0, 1, 0, 0, 0, 1, 5'd9, 0, 2'b00, 1, 1, 0, 1, 0, 0)); // ALU producer
    tbl.push_back(mk(0, 5'd3, 5'd4, 1, 1, 1, 0, 0, 5'd0, 0, 2'b01, 1, 1, 0, 1, 0, 0)); // redirect
    tbl.push_back(mk(0, 5'd3, 5'd4, 1, 1, 1, 1, 1, 5'd4, 0, 2'b10, 0, 1, 1, 1, 0, 0)); // redirect + lu
    tbl.push_back(mk(0, 5'd3, 5'd4, 1, 1, 1, 0, 0, 5'd4, 0, 2'b01, 1, 1, 0, 1, 0, 0)); // redirect recurs
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i), 1'b1);

    // DIV occupancy: hazards, redirect and a stray start are ignored while frozen.
    v_hz    = mk(0, 5'd6, 5'd0, 1, 0, 1, 1, 1, 5'd6, 0, 2'b10, 0, 0, 0, 1, 1, 1);
    v_hz_md = v_hz; v_hz_md.md = 1'b1;
    apply(v_rst, "div.rst", 1'b1);
    apply(v_md,  "div.c0", 1'b1);
    apply(v_hz,  "div.c1", 1'b1);
    apply(v_hz_md, "div.c2", 1'b1);
    apply(v_hz,  "div.c3", 1'b1);
    apply(mk(0, 5'd6, 5'd0, 1, 0, 1, 0, 0, 5'd0, 0, 2'b01, 1, 1, 0, 1, 0, 0), "div.release", 1'b1);
    apply(v_idle, "div.after", 1'b1);
`ifdef STALL_PERF_CNT_EN
    check("div.stall_total", u_if.stall_cycles, 32'd4);
`endif

    // Reset on the second MD_WAIT cycle discards the remaining count.
    apply(v_md,   "rstdiv.c0", 1'b1);
    apply(v_hz,   "rstdiv.c1", 1'b1);
    apply(v_rst,  "rstdiv.c2", 1'b0);
    apply(v_idle, "rstdiv.next", 1'b1);
    apply(v_idle, "rstdiv.next2", 1'b1);

`ifdef STALL_PERF_CNT_EN
    // Counter wrap: preload all-ones, then one load-use stall cycle.
    @(negedge clk);
    force dut.r_stall_cycles = 32'hFFFF_FFFF;
    #1;
    release dut.r_stall_cycles;
    exp_stall = 32'hFFFF_FFFF;
    apply(mk(0, 5'd5, 5'd0, 1, 0, 0, 1, 1, 5'd5, 0, 2'b10, 0, 1, 1, 1, 0, 0), "wrap.stall", 1'b1);
    apply(v_idle, "wrap.after", 1'b1);
    check("wrap.zero", u_if.stall_cycles, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
